// File: rtl/fft_frame_feeder.sv
// Buffers one 16/32/64-point frame of complex samples and replays it to the FFT core with a start strobe.
// Latency: replay starts the cycle after the last sample is captured, then N back-to-back cycles plus GAP idle cycles.
// Backpressure: requests are taken only in IDLE and samples only in LOAD; upstream stalls on cfg_ready/s_ready otherwise.
module fft_frame_feeder #(
    parameter int W   = 34,
    parameter int GAP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    input  logic [1:0]   cfg_mode,
    output logic         cfg_ready,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic         start,
    output logic [1:0]   mode,
    output logic [W-1:0] din,
    output logic         busy,
    output logic         frame_done,
    output logic         err
);

    // Wide enough to count 0..GAP-1; GAP=0 still gets a 1-bit (unused) counter.
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [6:0]     cnt;
    logic [6:0]     n_len;
    logic [GW-1:0]  gap_cnt;
    logic [W-1:0]   buf_mem [64];
    logic [5:0]     rd_addr;
    logic           cfg_acc;
    logic           cfg_legal;
    logic           s_acc;
    logic           load_last;
    logic           send_last;
    logic           gap_last;

    // Handshakes are decoded from the state register directly so they never depend on combinational outputs.
    assign cfg_acc   = cfg_valid && (state == ST_IDLE);
    assign cfg_legal = (cfg_mode != 2'b11);
    assign s_acc     = s_valid && (state == ST_LOAD);
    assign load_last = s_acc && (cnt == n_len - 7'd1);
    assign send_last = (state == ST_SEND) && (cnt == n_len - 7'd1);
    assign gap_last  = (state == ST_GAP) && (int'(gap_cnt) == GAP - 1);
    assign rd_addr   = cnt[5:0] + 6'd1;

    // Frame length follows the latched mode, which only changes on a legal request.
    always_comb begin
        n_len = 7'd16;
        case (mode)
            2'b01:   n_len = 7'd32;
            2'b10:   n_len = 7'd64;
            default: n_len = 7'd16;
        endcase
    end

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the state-derived flow-control outputs.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        s_ready   = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_acc && cfg_legal) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (load_last) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send_last) begin
                    state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sample buffer; contents are meaningless after an abandoned frame so it carries no reset.
    always_ff @(posedge clk) begin
        if (s_acc) begin
            buf_mem[cnt[5:0]] <= s_data;
        end
    end

    // Counters and registered chip-side outputs; din is prefetched one cycle ahead of each SEND slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            gap_cnt    <= '0;
            mode       <= 2'b00;
            din        <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_acc) begin
                        if (cfg_legal) begin
                            mode <= cfg_mode;
                            cnt  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (s_acc) begin
                        if (load_last) begin
                            // Slot 0 was written long ago, so it can be read while the last slot is written.
                            cnt   <= '0;
                            din   <= buf_mem[0];
                            start <= 1'b1;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                ST_SEND: begin
                    if (send_last) begin
                        din     <= '0;
                        gap_cnt <= '0;
                    end else begin
                        cnt        <= cnt + 7'd1;
                        din        <= buf_mem[rd_addr];
                        frame_done <= (cnt == n_len - 7'd2);
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
module tb_fft_frame_feeder;

    localparam int W = 34;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         cfg_valid = 1'b0;
    logic [1:0]   cfg_mode  = 2'b00;
    logic         cfg_ready;
    logic         s_valid   = 1'b0;
    logic [W-1:0] s_data    = '0;
    logic         s_ready;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] din;
    logic         busy;
    logic         frame_done;
    logic         err;

    logic         cfg_valid0 = 1'b0;
    logic [1:0]   cfg_mode0  = 2'b00;
    logic         cfg_ready0;
    logic         s_valid0   = 1'b0;
    logic [W-1:0] s_data0    = '0;
    logic         s_ready0;
    logic         start0;
    logic [1:0]   mode0;
    logic [W-1:0] din0;
    logic         busy0;
    logic         frame_done0;
    logic         err0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] dat;
        bit           st;
        bit           fd;
        bit           endm;
        logic [1:0]   md;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    exp_t mon_e;
    bit   mon_en   = 1'b0;
    bit   in_frame = 1'b0;

    fft_frame_feeder #(.W(W), .GAP(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .start(start), .mode(mode), .din(din), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    fft_frame_feeder #(.W(W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid0), .cfg_mode(cfg_mode0), .cfg_ready(cfg_ready0),
        .s_valid(s_valid0), .s_data(s_data0), .s_ready(s_ready0),
        .start(start0), .mode(mode0), .din(din0), .busy(busy0),
        .frame_done(frame_done0), .err(err0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic int nof(input logic [1:0] m);
        case (m)
            2'b00:   return 16;
            2'b01:   return 32;
            2'b10:   return 64;
            default: return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] sample(input logic [1:0] m, input int k);
        logic [16:0] re;
        logic [16:0] im;
        if (m == 2'b00) return W'(k);
        re = 17'(k + 1000 * int'(m));
        im = 17'(k) ^ 17'h1A5A5;
        return {re, im};
    endfunction

    // Scoreboard monitor: pops one expected sample per replay cycle, otherwise checks the bus is quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!in_frame && start === 1'b1) in_frame = 1'b1;
            if (in_frame) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: din=0x%0h start=%0b with nothing expected", din, start);
                    in_frame = 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mon_din", din, mon_e.dat);
                    chk("mon_start", start, mon_e.st);
                    chk("mon_frame_done", frame_done, mon_e.fd);
                    chk("mon_mode", mode, mon_e.md);
                    if (mon_e.endm) in_frame = 1'b0;
                end
            end else begin
                chk("idle_start", start, 0);
                chk("idle_frame_done", frame_done, 0);
                chk("idle_din", din, 0);
            end
            if (err === 1'b1) begin
                chk("mon_err_expected", err_q.size() > 0, 1);
                if (err_q.size() > 0) void'(err_q.pop_front());
            end
        end
    end

    // Present a request and return one cycle after it was accepted.
    task automatic request(input logic [1:0] m);
        int g;
        g = 0;
        cfg_valid = 1'b1;
        cfg_mode  = m;
        while (!cfg_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("cfg_accept_timeout", g < 500, 1);
        if (m == 2'b11) err_q.push_back(1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Feed N samples; expected replay entries are pushed as each sample is handed over.
    task automatic load(input logic [1:0] m, input bit bub, input int nkeep, output int rdy);
        int n;
        int k;
        int g;
        n = nof(m);
        k = 0;
        g = 0;
        rdy = 0;
        while (k < n && g < 1000) begin
            s_valid = 1'b0;
            if (s_ready) begin
                rdy++;
                if (!(bub && ((g % 5) == 2 || (g % 7) == 3))) begin
                    s_valid = 1'b1;
                    s_data  = sample(m, k);
                    if (k < nkeep) begin
                        exp_q.push_back('{dat: sample(m, k), st: (k == 0), fd: (k == n - 1),
                                          endm: (k == nkeep - 1), md: m});
                    end
                    k++;
                end
            end
            g++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("load_count", k, n);
        chk("s_ready_after_load", s_ready, 0);
    endtask

    task automatic wait_idle(input string name, input int expc);
        int c;
        c = 0;
        while (busy && c < 1000) begin
            c++;
            @(negedge clk);
        end
        chk(name, c, expc);
    endtask

    initial begin
        int  rdy;
        int  c;
        int  k;
        bit  mode_ok;

        // Reset with handshakes asserted: reset must win.
        cfg_valid = 1'b1;
        cfg_mode  = 2'b01;
        s_valid   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_mode", mode, 2'b00);
        chk("rst_din", din, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
        rst       = 1'b0;
        mon_en    = 1'b1;

        // 16-point frame, samples 0..15, s_valid held.
        request(2'b00);
        load(2'b00, 1'b0, 16, rdy);
        chk("m00_ready_cycles", rdy, 16);
        wait_idle("m00_busy_cycles", 20);

        // 64-point frame with upstream bubbles.
        request(2'b10);
        load(2'b10, 1'b1, 64, rdy);
        chk("m10_bubbles_seen", rdy > 64, 1);
        wait_idle("m10_busy_cycles", 68);

        // Illegal mode: error pulse only.
        request(2'b11);
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_s_ready", s_ready, 0);
        chk("ill_mode", mode, 2'b10);
        chk("ill_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        chk("ill_err_clear", err, 0);
        chk("ill_busy_after", busy, 0);
        chk("ill_s_ready_after", s_ready, 0);

        // Reset during SEND cycle 10 of a 32-point frame.
        request(2'b01);
        load(2'b01, 1'b0, 11, rdy);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_din", din, 0);
        chk("abort_start", start, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_mode", mode, 2'b00);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Request held high across a full 32-point frame.
        request(2'b01);
        cfg_valid = 1'b1;
        cfg_mode  = 2'b00;
        load(2'b01, 1'b0, 32, rdy);
        c = 0;
        mode_ok = 1'b1;
        while (!cfg_ready && c < 1000) begin
            if (mode !== 2'b01) mode_ok = 1'b0;
            c++;
            @(negedge clk);
        end
        chk("hold_wait_cycles", c, 36);
        chk("hold_mode_stable_01", mode_ok, 1);
        chk("hold_mode_at_accept", mode, 2'b01);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("hold_mode_after_accept", mode, 2'b00);
        chk("hold_second_load", s_ready, 1);
        load(2'b00, 1'b0, 16, rdy);
        wait_idle("hold_second_busy", 20);

        // GAP=0 build: back-to-back 16-point frames with the request held.
        cfg_valid0 = 1'b1;
        cfg_mode0  = 2'b00;
        chk("g0_cfg_ready", cfg_ready0, 1);
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            k = 0;
            c = 0;
            while (k < 16 && c < 100) begin
                s_valid0 = 1'b0;
                if (s_ready0) begin
                    s_valid0 = 1'b1;
                    s_data0  = W'(k);
                    k++;
                end
                c++;
                @(negedge clk);
            end
            s_valid0 = 1'b0;
            chk("g0_load_count", k, 16);
            chk("g0_start", start0, 1);
            chk("g0_mode", mode0, 2'b00);
            c = 0;
            while (!frame_done0 && c < 100) begin
                c++;
                @(negedge clk);
            end
            chk("g0_done_cycle", c, 15);
            chk("g0_last_din", din0, 15);
            if (f == 1) cfg_valid0 = 1'b0;
            @(negedge clk);
            chk("g0_idle_cfg_ready", cfg_ready0, 1);
            chk("g0_idle_busy", busy0, 0);
            @(negedge clk);
            if (f == 0) chk("g0_reaccept_load", s_ready0, 1);
            else        chk("g0_final_idle", busy0, 0);
        end
        chk("g0_err", err0, 0);

        repeat (4) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
